masked_serial_adder: RTL

- Digit-serial masked adder/subtractor. Operands arrive already split into NSHARES Boolean shares; every intermediate value, including the carry, stays in share form.
- Processes DIGIT bits per cycle. The carry share vector is held in registers between digits, so area scales with DIGIT, not WIDTH.
- Successor to the combinational masked ripple-carry adder. It adds fresh per-cycle randomness, subtract mode, a valid/ready handshake, and a parametric digit width.

---
 rtl/masked_pkg.sv | 31 +++
 rtl/masked_digit_adder.sv | 69 ++++++
 rtl/masked_serial_adder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/masked_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | masked_pkg                                                           |
// | Shared types and sizing helpers for the masked serial adder.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package masked_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fresh random bits consumed by one ISW masked AND over nshares shares.
  function automatic int rnd_per_and(input int nshares);
    return nshares * (nshares - 1) / 2;
  endfunction

  // Two AND gadgets per bit position.
  function automatic int rnd_per_cycle(input int nshares, input int digit);
    return 2 * digit * rnd_per_and(nshares);
  endfunction

  // Flat share-major layout: share k occupies [k*width +: width].
  function automatic int share_base(input int share, input int width);
    return share * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/masked_digit_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | masked_digit_adder                                                   |
// | Combinational DIGIT-bit full-adder slice in Boolean-share domain.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module masked_digit_adder
  import masked_pkg::*;
#(
  parameter int NSHARES = 3,
  parameter int DIGIT   = 8
) (
  input  logic [NSHARES*DIGIT-1:0]             a_dig,
  input  logic [NSHARES*DIGIT-1:0]             b_dig,
  input  logic [NSHARES-1:0]                   c_in,
  input  logic [DIGIT*NSHARES*(NSHARES-1)-1:0] rnd,
  output logic [NSHARES*DIGIT-1:0]             s_dig,
  output logic [NSHARES-1:0]                   c_out
);

  localparam int NR = rnd_per_and(NSHARES);

  // ISW gadget: pairwise cross terms are re-masked by one fresh bit each.
  function automatic logic [NSHARES-1:0] isw_and(
    input logic [NSHARES-1:0] x,
    input logic [NSHARES-1:0] y,
    input logic [NR-1:0]      r
  );
    logic [NSHARES-1:0] z;
    int idx;
    z   = x & y;
    idx = 0;
    for (int i = 0; i < NSHARES; i++) begin
      for (int j = i + 1; j < NSHARES; j++) begin
        z[i] = z[i] ^ r[idx];
        z[j] = z[j] ^ ((r[idx] ^ (x[i] & y[j])) ^ (x[j] & y[i]));
        idx++;
      end
    end
    return z;
  endfunction

  always_comb begin
    logic [NSHARES-1:0] w_a;
    logic [NSHARES-1:0] w_b;
    logic [NSHARES-1:0] w_p;
    logic [NSHARES-1:0] w_c;
    w_a   = '0;
    w_b   = '0;
    w_p   = '0;
    w_c   = c_in;
    s_dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      for (int k = 0; k < NSHARES; k++) begin
        w_a[k] = a_dig[k*DIGIT + i];
        w_b[k] = b_dig[k*DIGIT + i];
      end
      w_p = w_a ^ w_b;
      for (int k = 0; k < NSHARES; k++) begin
        s_dig[k*DIGIT + i] = w_p[k] ^ w_c[k];
      end
      w_c = isw_and(w_a, w_b, rnd[(2*i)*NR +: NR])
          ^ isw_and(w_c, w_p, rnd[(2*i+1)*NR +: NR]);
    end
    c_out = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/masked_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | masked_serial_adder                                                  |
// | Digit-serial masked add/subtract with valid/ready handshake.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module masked_serial_adder
  import masked_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NSHARES = 3,
  parameter int DIGIT   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 sub,
  input  logic [NSHARES*WIDTH-1:0]             a_sh,
  input  logic [NSHARES*WIDTH-1:0]             b_sh,
  input  logic [NSHARES-1:0]                   cin_sh,
  input  logic [DIGIT*NSHARES*(NSHARES-1)-1:0] rnd,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NSHARES*WIDTH-1:0]             sum_sh,
  output logic [NSHARES-1:0]                   cout_sh
);

  localparam int NCYC  = WIDTH / DIGIT;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCYC - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("masked_serial_adder: WIDTH must be a multiple of DIGIT");
  end
  if (NSHARES < 2) begin : g_bad_shares
    $error("masked_serial_adder: NSHARES must be at least 2");
  end

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [NSHARES*WIDTH-1:0] r_a;
  logic [NSHARES*WIDTH-1:0] r_b;
  logic [NSHARES*WIDTH-1:0] r_sum;
  logic [NSHARES-1:0]       r_c;
  logic                     r_out_valid;

  logic [NSHARES*DIGIT-1:0] w_a_dig;
  logic [NSHARES*DIGIT-1:0] w_b_dig;
  logic [NSHARES*DIGIT-1:0] w_s_dig;
  logic [NSHARES-1:0]       w_c_next;
  logic [NSHARES*WIDTH-1:0] w_b_load;
  logic [NSHARES-1:0]       w_c_load;
  logic                     w_accept;

  assign in_ready  = ~rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept  = in_ready & in_valid;
  assign out_valid = r_out_valid;
  assign sum_sh    = r_sum;
  assign cout_sh   = r_c;

  // Flipping only share 0 negates the unmasked b; the +1 enters as carry share 0.
  assign w_b_load = b_sh ^ {{((NSHARES-1)*WIDTH){1'b0}}, {WIDTH{sub}}};
  assign w_c_load = sub ? NSHARES'(1) : cin_sh;

  // Operands shift right each digit, so the live digit always sits at the LSBs.
  for (genvar k = 0; k < NSHARES; k++) begin : g_dig
    assign w_a_dig[k*DIGIT +: DIGIT] = r_a[share_base(k, WIDTH) +: DIGIT];
    assign w_b_dig[k*DIGIT +: DIGIT] = r_b[share_base(k, WIDTH) +: DIGIT];
  end

  masked_digit_adder #(
    .NSHARES (NSHARES),
    .DIGIT   (DIGIT)
  ) u_digit (
    .a_dig (w_a_dig),
    .b_dig (w_b_dig),
    .c_in  (r_c),
    .rnd   (rnd),
    .s_dig (w_s_dig),
    .c_out (w_c_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a         <= a_sh;
            r_b         <= w_b_load;
            r_c         <= w_c_load;
            r_cnt       <= '0;
            r_state     <= RUN;
            r_out_valid <= 1'b0;
          end else if ((r_state == DONE) && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        RUN: begin
          for (int k = 0; k < NSHARES; k++) begin
            r_a[k*WIDTH +: WIDTH] <= r_a[k*WIDTH +: WIDTH] >> DIGIT;
            r_b[k*WIDTH +: WIDTH] <= r_b[k*WIDTH +: WIDTH] >> DIGIT;
            r_sum[k*WIDTH + int'(r_cnt)*DIGIT +: DIGIT] <= w_s_dig[k*DIGIT +: DIGIT];
          end
          r_c <= w_c_next;
          if (r_cnt == C_LAST) begin
            r_cnt       <= '0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
